// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside decode: tracks pending fixed- and variable-latency
// writes, stalls on RAW/WAW hazards and flags operands to be taken from the bypass path.
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int LATW  = 3,
  parameter bit FWD   = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ISSUE_VALID,
  input  logic [AW-1:0]    ISSUE_RS1,
  input  logic [AW-1:0]    ISSUE_RS2,
  input  logic             ISSUE_USE1,
  input  logic             ISSUE_USE2,
  input  logic [AW-1:0]    ISSUE_RD,
  input  logic             ISSUE_WEN,
  input  logic [LATW-1:0]  ISSUE_LAT,
  input  logic             FLUSH,
  input  logic             WB_VALID,
  input  logic [AW-1:0]    WB_RD,
  output logic             STALL,
  output logic             FWD_RS1,
  output logic             FWD_RS2,
  output logic [NREGS-1:0] BUSY_VEC,
  output logic [AW:0]      OUTSTANDING,
  output logic             ERR_SPUR
);

  logic [NREGS-1:0] busy_q, var_q, busy_d, var_d;
  logic [LATW-1:0]  cnt_q [NREGS];
  logic [LATW-1:0]  cnt_d [NREGS];
  logic [AW:0]      outstanding_q;
  logic             err_q, err_d;
  logic             byp1, byp2, ready1, ready2, waw, stall, accept;

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < NREGS; i++) n = n + {{AW{1'b0}}, v[i]};
    return n;
  endfunction

  // An operand is bypassable when its fixed-latency producer lands on the coming edge.
  assign byp1 = FWD && (ISSUE_RS1 != '0) && busy_q[ISSUE_RS1] && !var_q[ISSUE_RS1]
                && (cnt_q[ISSUE_RS1] == LATW'(1));
  assign byp2 = FWD && (ISSUE_RS2 != '0) && busy_q[ISSUE_RS2] && !var_q[ISSUE_RS2]
                && (cnt_q[ISSUE_RS2] == LATW'(1));
  assign ready1 = (ISSUE_RS1 == '0) || !busy_q[ISSUE_RS1] || byp1;
  assign ready2 = (ISSUE_RS2 == '0) || !busy_q[ISSUE_RS2] || byp2;
  assign waw    = ISSUE_WEN && (ISSUE_RD != '0) && busy_q[ISSUE_RD];

  assign stall  = !RESET && ISSUE_VALID
                  && ((ISSUE_USE1 && !ready1) || (ISSUE_USE2 && !ready2) || waw);
  assign accept = !RESET && ISSUE_VALID && !stall && !FLUSH && ISSUE_WEN && (ISSUE_RD != '0);

  always_comb begin
    busy_d = busy_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    for (int i = 1; i < NREGS; i++) begin
      if (busy_q[i] && !var_q[i]) begin
        cnt_d[i] = cnt_q[i] - LATW'(1);
        if (cnt_q[i] == LATW'(1)) busy_d[i] = 1'b0;
      end
    end
    if (WB_VALID && (WB_RD != '0)) begin
      if (busy_q[WB_RD] && var_q[WB_RD]) begin
        busy_d[WB_RD] = 1'b0;
        var_d[WB_RD]  = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (accept) begin
      busy_d[ISSUE_RD] = 1'b1;
      var_d[ISSUE_RD]  = (ISSUE_LAT == '0);
      cnt_d[ISSUE_RD]  = ISSUE_LAT;
    end
    busy_d[0] = 1'b0;
    var_d[0]  = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_q        <= '0;
      var_q         <= '0;
      err_q         <= 1'b0;
      outstanding_q <= '0;
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      busy_q        <= busy_d;
      var_q         <= var_d;
      err_q         <= err_d;
      outstanding_q <= popcount(busy_d);
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign STALL       = stall;
  assign FWD_RS1     = !RESET && ISSUE_USE1 && byp1;
  assign FWD_RS2     = !RESET && ISSUE_USE2 && byp2;
  assign BUSY_VEC    = RESET ? '0 : busy_q;
  assign OUTSTANDING = RESET ? '0 : outstanding_q;
  assign ERR_SPUR    = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a bypassing (FWD=1) and a non-bypassing (FWD=0) instance
// share stimulus; per-cycle expectations are queued at drive time and popped at the negedge.
module tb_hazard_scoreboard;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ISSUE_VALID, ISSUE_USE1, ISSUE_USE2, ISSUE_WEN, FLUSH, WB_VALID;
  logic [4:0]  ISSUE_RS1, ISSUE_RS2, ISSUE_RD, WB_RD;
  logic [2:0]  ISSUE_LAT;

  logic        st_a, f1_a, f2_a, err_a;
  logic        st_b, f1_b, f2_b, err_b;
  logic [31:0] bv_a, bv_b;
  logic [5:0]  out_a, out_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wen;
    logic [2:0] lat;
    logic       flush;
    logic       wbv;
    logic [4:0] wbrd;
  } stim_t;

  // sa/fa: STALL/FWD_RS1 of FWD=1 instance; sb/fb: same for FWD=0; bz: watched BUSY_VEC bit
  typedef struct packed {
    logic sa, fa, sb, fb, bz;
  } exp_t;

  exp_t sb_q[$];

  hazard_scoreboard #(.NREGS(32), .AW(5), .LATW(3), .FWD(1'b1)) u_fwd (
    .CLK(CLK), .RESET(RESET), .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1(ISSUE_RS1),
    .ISSUE_RS2(ISSUE_RS2), .ISSUE_USE1(ISSUE_USE1), .ISSUE_USE2(ISSUE_USE2),
    .ISSUE_RD(ISSUE_RD), .ISSUE_WEN(ISSUE_WEN), .ISSUE_LAT(ISSUE_LAT), .FLUSH(FLUSH),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .STALL(st_a), .FWD_RS1(f1_a), .FWD_RS2(f2_a),
    .BUSY_VEC(bv_a), .OUTSTANDING(out_a), .ERR_SPUR(err_a));

  hazard_scoreboard #(.NREGS(32), .AW(5), .LATW(3), .FWD(1'b0)) u_nofwd (
    .CLK(CLK), .RESET(RESET), .ISSUE_VALID(ISSUE_VALID), .ISSUE_RS1(ISSUE_RS1),
    .ISSUE_RS2(ISSUE_RS2), .ISSUE_USE1(ISSUE_USE1), .ISSUE_USE2(ISSUE_USE2),
    .ISSUE_RD(ISSUE_RD), .ISSUE_WEN(ISSUE_WEN), .ISSUE_LAT(ISSUE_LAT), .FLUSH(FLUSH),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .STALL(st_b), .FWD_RS1(f1_b), .FWD_RS2(f2_b),
    .BUSY_VEC(bv_b), .OUTSTANDING(out_b), .ERR_SPUR(err_b));

  always #5 CLK = ~CLK;

  localparam stim_t IDLE = '0;

  function automatic stim_t iss(input logic [4:0] rd, input logic [2:0] lat);
    stim_t s = '0;
    s.v = 1'b1; s.rd = rd; s.wen = 1'b1; s.lat = lat;
    return s;
  endfunction

  function automatic stim_t rdr(input logic [4:0] rs);
    stim_t s = '0;
    s.v = 1'b1; s.rs1 = rs; s.u1 = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    ISSUE_VALID = s.v;   ISSUE_RS1 = s.rs1; ISSUE_USE1 = s.u1;
    ISSUE_RS2   = s.rs2; ISSUE_USE2 = s.u2; ISSUE_RD  = s.rd;
    ISSUE_WEN   = s.wen; ISSUE_LAT  = s.lat; FLUSH    = s.flush;
    WB_VALID    = s.wbv; WB_RD      = s.wbrd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    RESET = 1'b1;
    apply(IDLE);
    tick(); tick();
    RESET = 1'b0;
    apply(rdr(5'd1));
    @(negedge CLK);
    n_tests++;
    if ({st_a, st_b, bv_a, bv_b, out_a, out_b, err_a, err_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: stall=%b/%b busy=%h/%h out=%0d/%0d err=%b/%b want all 0",
               st_a, st_b, bv_a, bv_b, out_a, out_b, err_a, err_b);
    end
    tick();
    for (int c = 0; c < 24; c++) begin
      s = '0;
      s.v = 1'b1; s.wen = 1'b1; s.rd = 5'($urandom_range(1, 31));
      s.lat = 3'($urandom_range(0, 7)); s.rs1 = 5'($urandom_range(0, 31)); s.u1 = 1'($urandom);
      s.wbv = 1'($urandom); s.wbrd = 5'($urandom_range(0, 31));
      apply(s);
      tick();
    end
    RESET = 1'b1;
    apply(rdr(5'($urandom_range(1, 31))));
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      n_tests++;
      if ({st_a, st_b, f1_a, f1_b, bv_a, bv_b, out_a, out_b} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold c%0d: stall=%b/%b fwd=%b/%b busy=%h/%h out=%0d/%0d want 0",
                 c, st_a, st_b, f1_a, f1_b, bv_a, bv_b, out_a, out_b);
      end
      tick();
    end
    RESET = 1'b0;
    apply(IDLE);
    @(negedge CLK);
    n_tests++;
    if ({bv_a, bv_b, out_a, out_b, err_a, err_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_after: busy=%h/%h out=%0d/%0d err=%b/%b want 0",
               bv_a, bv_b, out_a, out_b, err_a, err_b);
    end
    tick();
  endtask

  task automatic test_fixed_raw();
    stim_t seq[5];
    exp_t  ex[5];
    exp_t  e;
    seq = '{iss(5'd5, 3'd3), IDLE, rdr(5'd5), rdr(5'd5), rdr(5'd5)};
    ex  = '{5'b00000, 5'b00001, 5'b10101, 5'b01101, 5'b00000};
    for (int c = 0; c < 5; c++) begin
      apply(seq[c]);
      sb_q.push_back(ex[c]);
      @(negedge CLK);
      e = sb_q.pop_front();
      n_tests++;
      if ({st_a, f1_a, st_b, f1_b, bv_a[5], bv_b[5]} !== {e.sa, e.fa, e.sb, e.fb, e.bz, e.bz}) begin
        n_fail++;
        $display("FAIL fixed_raw c%0d: got %b want %b", c,
                 {st_a, f1_a, st_b, f1_b, bv_a[5], bv_b[5]}, {e.sa, e.fa, e.sb, e.fb, e.bz, e.bz});
      end
      if (c == 1) begin
        n_tests++;
        if (out_a !== 6'd1 || out_b !== 6'd1) begin
          n_fail++;
          $display("FAIL fixed_raw_outstanding: got %0d/%0d want 1", out_a, out_b);
        end
      end
      tick();
    end
    apply(IDLE);
  endtask

  task automatic test_variable();
    stim_t s;
    exp_t  e;
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin
        s = iss(5'd7, 3'd0);
        sb_q.push_back(5'b00000);
      end else if (c < 11) begin
        s = rdr(5'd7);
        s.wbv = (c == 10); s.wbrd = 5'd7;
        sb_q.push_back(5'b10101);
      end else begin
        s = rdr(5'd7);
        sb_q.push_back(5'b00000);
      end
      apply(s);
      @(negedge CLK);
      e = sb_q.pop_front();
      n_tests++;
      if ({st_a, f1_a, st_b, f1_b, bv_a[7], bv_b[7]} !== {e.sa, e.fa, e.sb, e.fb, e.bz, e.bz}) begin
        n_fail++;
        $display("FAIL variable c%0d: got %b want %b", c,
                 {st_a, f1_a, st_b, f1_b, bv_a[7], bv_b[7]}, {e.sa, e.fa, e.sb, e.fb, e.bz, e.bz});
      end
      tick();
    end
    apply(IDLE);
    @(negedge CLK);
    n_tests++;
    if ({err_a, err_b, out_a, out_b} !== '0) begin
      n_fail++;
      $display("FAIL variable_clean: err=%b/%b out=%0d/%0d want 0", err_a, err_b, out_a, out_b);
    end
    tick();
  endtask

  task automatic test_waw();
    stim_t seq[6];
    exp_t  ex[6];
    exp_t  e;
    seq = '{iss(5'd3, 3'd2), iss(5'd3, 3'd1), iss(5'd3, 3'd1), iss(5'd3, 3'd1), IDLE, IDLE};
    ex  = '{5'b00000, 5'b10101, 5'b10101, 5'b00000, 5'b00001, 5'b00000};
    for (int c = 0; c < 6; c++) begin
      apply(seq[c]);
      sb_q.push_back(ex[c]);
      @(negedge CLK);
      e = sb_q.pop_front();
      n_tests++;
      if ({st_a, f1_a, st_b, f1_b, bv_a[3], bv_b[3]} !== {e.sa, e.fa, e.sb, e.fb, e.bz, e.bz}) begin
        n_fail++;
        $display("FAIL waw c%0d: got %b want %b", c,
                 {st_a, f1_a, st_b, f1_b, bv_a[3], bv_b[3]}, {e.sa, e.fa, e.sb, e.fb, e.bz, e.bz});
      end
      tick();
    end
  endtask

  task automatic test_x0_and_flush();
    stim_t s;
    s = '0;
    s.v = 1'b1; s.u1 = 1'b1; s.u2 = 1'b1; s.wen = 1'b1; s.wbv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      apply(s);
      @(negedge CLK);
      n_tests++;
      if ({st_a, st_b, f1_a, f2_a, bv_a, bv_b, out_a, err_a} !== '0) begin
        n_fail++;
        $display("FAIL x0 c%0d: stall=%b/%b fwd=%b%b busy=%h/%h out=%0d err=%b want 0",
                 c, st_a, st_b, f1_a, f2_a, bv_a, bv_b, out_a, err_a);
      end
      tick();
    end
    s = iss(5'd9, 3'd2);
    s.flush = 1'b1;
    apply(s);
    @(negedge CLK);
    n_tests++;
    if (st_a !== 1'b0 || st_b !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: got %b/%b want 0", st_a, st_b);
    end
    tick();
    apply(IDLE);
    @(negedge CLK);
    n_tests++;
    if (bv_a[9] !== 1'b0 || bv_b[9] !== 1'b0 || out_a !== 6'd0 || out_b !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_reserve: busy9=%b/%b out=%0d/%0d want 0", bv_a[9], bv_b[9], out_a, out_b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    apply(iss(5'd10, 3'd1));
    tick();
    apply(iss(5'd11, 3'd2));
    @(negedge CLK);
    n_tests++;
    if (st_a !== 1'b0 || bv_a[10] !== 1'b1 || bv_a[11] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_issue: stall=%b busy10=%b busy11=%b want 0 1 0", st_a, bv_a[10], bv_a[11]);
    end
    tick();
    apply(IDLE);
    @(negedge CLK);
    n_tests++;
    if (bv_a[10] !== 1'b0 || bv_a[11] !== 1'b1 || out_a !== 6'd1 || bv_b !== bv_a) begin
      n_fail++;
      $display("FAIL b2b_clear_issue: busy10=%b busy11=%b out=%0d want 0 1 1", bv_a[10], bv_a[11], out_a);
    end
    tick(); tick();
  endtask

  task automatic test_spur_and_midop_reset();
    stim_t s;
    s = '0;
    s.wbv = 1'b1; s.wbrd = 5'd4;
    apply(s);
    @(negedge CLK);
    n_tests++;
    if (err_a !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_latency: got %b want 0", err_a);
    end
    tick();
    apply(IDLE);
    tick(); tick();
    @(negedge CLK);
    n_tests++;
    if (err_a !== 1'b1 || err_b !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_sticky: got %b/%b want 1", err_a, err_b);
    end
    tick();
    apply(iss(5'd4, 3'd0));
    tick();
    apply(iss(5'd6, 3'd7));
    tick();
    apply(rdr(5'd4));
    @(negedge CLK);
    n_tests++;
    if (bv_a[4] !== 1'b1 || bv_a[6] !== 1'b1 || out_a !== 6'd2 || st_a !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: busy4=%b busy6=%b out=%0d stall=%b want 1 1 2 1",
               bv_a[4], bv_a[6], out_a, st_a);
    end
    tick();
    RESET = 1'b1;
    @(negedge CLK);
    n_tests++;
    if ({st_a, st_b, bv_a, out_a} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset_hold: stall=%b/%b busy=%h out=%0d want 0", st_a, st_b, bv_a, out_a);
    end
    tick();
    RESET = 1'b0;
    apply(IDLE);
    @(negedge CLK);
    n_tests++;
    if ({bv_a, bv_b, out_a, out_b, err_a, err_b} !== '0) begin
      n_fail++;
      $display("FAIL midop_reset_after: busy=%h/%h out=%0d/%0d err=%b/%b want 0",
               bv_a, bv_b, out_a, out_b, err_a, err_b);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed_raw();
    test_variable();
    test_waw();
    test_x0_and_flush();
    test_back_to_back();
    test_spur_and_midop_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
